nf_rule_join_avlstrm: RTL and testbench
=======================================

Name: nf_rule_join_avlstrm

Overview:
- Sits directly downstream of the non-fast-pattern stage (after its check/nocheck fork).
- Consumes three independent per-packet streams: the checked packet, its metadata, and its matched-rule stream.
- Re-serialises them into strict per-packet order for the host/DMA egress stage:
  - all rules of packet N first,
  - then one metadata beat carrying the accepted rule count and an overflow flag,
  - then the packet beats of packet N.
- Guarantees that egress never sees the streams of two packets interleaved.

Parameters:
PKT_W, 512, packet data width (avl_stream_if data)
META_W, 512, input metadata width
RULE_W, 512, rule stream data width; rule ID in bits [15:0], 0 = "no rule"
MAX_RULES, 32, max rules forwarded per packet; extra rules consumed and dropped
RCNT_W, 16, rule-count field width

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
in_pkt  avl_stream_if.rx  PKT_W  packet beats (sop/eop/empty)
in_meta  avl_stream_if.rx  META_W  one beat per packet
in_usr  avl_stream_if.rx  RULE_W  one rule per beat; eop marks last rule of a packet
out_pkt  avl_stream_if.tx  PKT_W  packet beats, passthrough
out_meta  avl_stream_if.tx  META_W+RCNT_W+1  {overflow, rule_cnt, meta}
out_usr  avl_stream_if.tx  RULE_W  accepted rules
stats_pkt  out  32  packets completed (eop accepted on out_pkt)
stats_rule  out  32  rules forwarded
stats_drop_rule  out  32  rules dropped (over MAX_RULES)

Behaviour:
- Reset (Rst_n=0, async):
  - state=IDLE;
  - all out_*.valid=0; all in_*.ready=0;
  - counters, meta_reg, rule_cnt, ovf cleared.
  - Reset asserted mid-packet abandons that packet; no partial output after release.
- Handshake: a beat transfers when valid&&ready in the same cycle. valid never depends combinationally on ready.
- Only the stream the FSM currently targets has its ready asserted. ready=0 for every other stream.
- IDLE:
  - in_meta.ready=1.
  - On accept: meta_reg<=data; rule_cnt<=0; ovf<=0; go to RULE.
- RULE:
  - For each in_usr beat:
    - Forward it to out_usr (in_usr.ready=out_usr.ready) when rule ID!=0 and rule_cnt<MAX_RULES; rule_cnt increments.
    - If rule ID!=0 and rule_cnt==MAX_RULES: ready=1, beat dropped, ovf<=1, stats_drop_rule++.
    - If rule ID==0: consumed, not forwarded, count unchanged.
  - out_usr.sop/eop are regenerated:
    - sop on the first forwarded rule;
    - eop on the forwarded rule that coincides with in_usr eop.
    - If the eop beat itself is dropped or ID 0, a zero-data eop-only marker beat is emitted, and only if at least one rule was forwarded.
  - On accepting the in_usr beat with eop: go to META.
- META:
  - out_meta.valid=1; data={ovf, rule_cnt, meta_reg}; sop=eop=1.
  - On ready: go to PKT.
- PKT:
  - in_pkt passes through combinationally: out_pkt.valid=in_pkt.valid, in_pkt.ready=out_pkt.ready.
  - On accepted eop: stats_pkt++; go to IDLE.
- Zero-rule packet (single ID-0 eop beat): no out_usr beats; meta carries rule_cnt=0.
- Latency:
  - meta out 1 cycle after the in_usr eop accept (registered);
  - rule and pkt paths have 0 added cycles (passthrough).
- Counters wrap at 2^32. rule_cnt never exceeds MAX_RULES.

Optional Feature:
- Macro NF_JOIN_SOP_CHECK_EN.
- When defined:
  - In PKT state, an in_pkt beat that has sop=1 and is not the first beat of the packet is an error.
  - The error sets a sticky output proto_err (1 bit, reset 0) and forces eop=1 on that forwarded beat.
  - The FSM then returns to IDLE.
- When undefined: no proto_err port; sop is passed through unchecked.

Decomposition:
- Shared package nf_join_pkg holds:
  - state enum (IDLE, RULE, META, PKT);
  - out_meta struct {ovf, rule_cnt, meta};
  - RULE_ID_NONE = 16'd0.
- One natural sub-module, nf_join_stats, holds the three saturation-free 32-bit counters with increment strobes.

Test Plan:
- 1 packet, meta M, rules {5,9,12} (eop on 12), 3-beat packet -> out_usr 5,9,12 (sop on 5, eop on 12), then out_meta {0,3,M}, then 3 pkt beats; stats_pkt=1, stats_rule=3.
- Zero-rule packet (single ID-0 eop beat) -> no out_usr beats, out_meta {0,0,M}, packet forwarded.
- 40 rules with MAX_RULES=32 -> 32 forwarded, eop-only marker beat, out_meta {1,32,M}, stats_drop_rule=8.
- Random out_*.ready backpressure (50%) with 100 back-to-back packets -> per-packet ordering rules→meta→pkt holds, no beat lost or duplicated, counts match the model.
- Rst_n pulsed low during PKT state -> all valids drop asynchronously, counters=0; the next packet is processed cleanly from IDLE.
- With NF_JOIN_SOP_CHECK_EN, sop on beat 2 of a packet -> proto_err=1 (sticky), that beat emitted with eop=1, FSM back in IDLE.

Source files
------------

// File: rtl/nf_join_pkg.sv
// Shared types and defaults for the rule/meta/packet join stage.
package nf_join_pkg;

    localparam int unsigned PKT_W_DEF     = 512;
    localparam int unsigned META_W_DEF    = 512;
    localparam int unsigned RULE_W_DEF    = 512;
    localparam int unsigned MAX_RULES_DEF = 32;
    localparam int unsigned RCNT_W_DEF    = 16;

    localparam logic [15:0] RULE_ID_NONE = 16'd0;

    typedef enum logic [1:0] {
        IDLE,
        RULE,
        META,
        PKT
    } join_state_t;

    typedef struct packed {
        logic                  ovf;
        logic [RCNT_W_DEF-1:0] rule_cnt;
        logic [META_W_DEF-1:0] meta;
    } meta_out_t;

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST style stream bundle with sop/eop/empty sideband.
interface avl_stream_if #(
    parameter int unsigned W       = 512,
    parameter int unsigned EMPTY_W = (W > 8) ? $clog2(W / 8) : 1
);
    logic [W-1:0]       data;
    logic               valid;
    logic               ready;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;

    modport rx (input data, valid, sop, eop, empty, output ready);
    modport tx (output data, valid, sop, eop, empty, input ready);
endinterface

// File: rtl/nf_join_stats.sv
// Free-running 32-bit event counters for the join stage; wrap at 2^32.
module nf_join_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_pkt,
    input  logic        inc_rule,
    input  logic        inc_drop,
    output logic [31:0] pkt_cnt,
    output logic [31:0] rule_cnt,
    output logic [31:0] drop_cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            rule_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (inc_pkt)  pkt_cnt  <= pkt_cnt + 32'd1;
            if (inc_rule) rule_cnt <= rule_cnt + 32'd1;
            if (inc_drop) drop_cnt <= drop_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/nf_rule_join_avlstrm.sv
// Re-serialises per-packet rules -> meta -> packet beats for egress.
// Optional NF_JOIN_SOP_CHECK_EN adds sticky proto_err for a stray mid-packet sop.
module nf_rule_join_avlstrm
    import nf_join_pkg::*;
#(
    parameter int unsigned PKT_W     = PKT_W_DEF,
    parameter int unsigned META_W    = META_W_DEF,
    parameter int unsigned RULE_W    = RULE_W_DEF,
    parameter int unsigned MAX_RULES = MAX_RULES_DEF,
    parameter int unsigned RCNT_W    = RCNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    avl_stream_if.rx    in_pkt,
    avl_stream_if.rx    in_meta,
    avl_stream_if.rx    in_usr,
    avl_stream_if.tx    out_pkt,
    avl_stream_if.tx    out_meta,
    avl_stream_if.tx    out_usr,
    output logic [31:0] stats_pkt,
    output logic [31:0] stats_rule,
    output logic [31:0] stats_drop_rule
`ifdef NF_JOIN_SOP_CHECK_EN
    ,
    output logic        proto_err
`endif
);
    join_state_t       state, state_nx;
    logic              armed;
    logic [META_W-1:0] meta_reg;
    logic [RCNT_W-1:0] rule_cnt;
    logic              ovf;
    logic [15:0]       rule_id;
    logic              rule_fwd, usr_rdy;
    logic              meta_acc, usr_acc, fwd_acc, drop_acc, pkt_acc, pkt_done;
    logic              sop_err, pkt_eop_out;
    logic              unused_sideband;

    assign unused_sideband = ^{in_meta.sop, in_meta.eop, in_meta.empty, in_usr.sop, in_usr.empty};

    assign rule_id     = in_usr.data[15:0];
    assign rule_fwd    = (rule_id != RULE_ID_NONE) && (rule_cnt < RCNT_W'(MAX_RULES));
    assign pkt_eop_out = in_pkt.eop || sop_err;

    assign meta_acc = (state == IDLE) && in_meta.valid && armed;
    assign usr_acc  = (state == RULE) && in_usr.valid && usr_rdy;
    assign fwd_acc  = usr_acc && rule_fwd;
    assign drop_acc = usr_acc && (rule_id != RULE_ID_NONE) && !rule_fwd;
    assign pkt_acc  = (state == PKT) && in_pkt.valid && out_pkt.ready;
    assign pkt_done = pkt_acc && pkt_eop_out;

    always_comb begin
        state_nx       = state;
        usr_rdy        = 1'b0;
        in_meta.ready  = 1'b0;
        in_usr.ready   = 1'b0;
        in_pkt.ready   = 1'b0;
        out_usr.valid  = 1'b0;
        out_usr.data   = '0;
        out_usr.sop    = 1'b0;
        out_usr.eop    = 1'b0;
        out_usr.empty  = '0;
        out_meta.valid = 1'b0;
        out_meta.data  = {ovf, rule_cnt, meta_reg};
        out_meta.sop   = 1'b1;
        out_meta.eop   = 1'b1;
        out_meta.empty = '0;
        out_pkt.valid  = 1'b0;
        out_pkt.data   = in_pkt.data[PKT_W-1:0];
        out_pkt.sop    = in_pkt.sop;
        out_pkt.eop    = pkt_eop_out;
        out_pkt.empty  = in_pkt.empty;
        case (state)
            IDLE: begin
                in_meta.ready = armed;
                if (in_meta.valid && armed) state_nx = RULE;
            end
            RULE: begin
                if (rule_fwd) begin
                    out_usr.valid = in_usr.valid;
                    out_usr.data  = in_usr.data[RULE_W-1:0];
                    out_usr.sop   = (rule_cnt == '0);
                    out_usr.eop   = in_usr.eop;
                    usr_rdy       = out_usr.ready;
                end else if (in_usr.eop && (rule_cnt != '0)) begin
                    // Unforwarded last rule still has to close the open out_usr frame.
                    out_usr.valid = in_usr.valid;
                    out_usr.eop   = 1'b1;
                    usr_rdy       = out_usr.ready;
                end else begin
                    usr_rdy = 1'b1;
                end
                in_usr.ready = usr_rdy;
                if (in_usr.valid && usr_rdy && in_usr.eop) state_nx = META;
            end
            META: begin
                out_meta.valid = 1'b1;
                if (out_meta.ready) state_nx = PKT;
            end
            PKT: begin
                out_pkt.valid = in_pkt.valid;
                in_pkt.ready  = out_pkt.ready;
                if (in_pkt.valid && out_pkt.ready && pkt_eop_out) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            meta_reg <= '0;
            rule_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (meta_acc) begin
                meta_reg <= in_meta.data[META_W-1:0];
                rule_cnt <= '0;
                ovf      <= 1'b0;
            end
            if (fwd_acc)  rule_cnt <= rule_cnt + RCNT_W'(1);
            if (drop_acc) ovf      <= 1'b1;
        end
    end

`ifdef NF_JOIN_SOP_CHECK_EN
    logic pkt_first;

    assign sop_err = in_pkt.sop && !pkt_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_first <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if ((state == META) && out_meta.ready) pkt_first <= 1'b1;
            else if (pkt_acc)                      pkt_first <= 1'b0;
            if (pkt_acc && sop_err)                proto_err <= 1'b1;
        end
    end
`else
    assign sop_err = 1'b0;
`endif

    nf_join_stats u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_pkt  (pkt_done),
        .inc_rule (fwd_acc),
        .inc_drop (drop_acc),
        .pkt_cnt  (stats_pkt),
        .rule_cnt (stats_rule),
        .drop_cnt (stats_drop_rule)
    );
endmodule

// File: tb/tb_nf_rule_join_avlstrm.sv
// Directed bench for nf_rule_join_avlstrm: ordering, overflow, backpressure, reset.
// Honours NF_JOIN_SOP_CHECK_EN when the design is built with it.
module tb_nf_rule_join_avlstrm;
    import nf_join_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    avl_stream_if #(.W(512)) pkt_i ();
    avl_stream_if #(.W(512)) meta_i ();
    avl_stream_if #(.W(512)) usr_i ();
    avl_stream_if #(.W(512)) pkt_o ();
    avl_stream_if #(.W(529)) meta_o ();
    avl_stream_if #(.W(512)) usr_o ();

    logic [31:0] stats_pkt, stats_rule, stats_drop_rule;
`ifdef NF_JOIN_SOP_CHECK_EN
    logic proto_err;
`endif

    nf_rule_join_avlstrm #(
        .PKT_W     (512),
        .META_W    (512),
        .RULE_W    (512),
        .MAX_RULES (32),
        .RCNT_W    (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_pkt          (pkt_i),
        .in_meta         (meta_i),
        .in_usr          (usr_i),
        .out_pkt         (pkt_o),
        .out_meta        (meta_o),
        .out_usr         (usr_o),
        .stats_pkt       (stats_pkt),
        .stats_rule      (stats_rule),
        .stats_drop_rule (stats_drop_rule)
`ifdef NF_JOIN_SOP_CHECK_EN
        ,
        .proto_err       (proto_err)
`endif
    );

    typedef struct {
        logic [511:0] d;
        logic         sop;
        logic         eop;
        logic [5:0]   emp;
    } pbeat_t;

    typedef struct {
        logic [511:0] d;
        logic         eop;
    } ubeat_t;

    int unsigned  total = 0;
    int unsigned  bad   = 0;
    int unsigned  seq   = 0;
    int unsigned  pidx  = 0;
    int unsigned  exp_pkt, exp_rule, exp_drop;
    bit           bp       = 1'b0;
    bit           hold_pkt = 1'b0;
    int unsigned  rid[$];
    logic [511:0] mq[$];
    ubeat_t       uq[$];
    pbeat_t       pq[$];
    logic [599:0] expq[$];
    logic [599:0] obsq[$];

    function automatic logic [599:0] enc(input logic [1:0] k, input logic s, input logic e,
                                         input logic [6:0] em, input logic [528:0] d);
        return {60'd0, k, s, e, em, d};
    endfunction

    task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        meta_i.valid = 1'b0; meta_i.data = '0;
        usr_i.valid  = 1'b0; usr_i.data  = '0; usr_i.eop = 1'b0;
        pkt_i.valid  = 1'b0; pkt_i.data  = '0; pkt_i.sop = 1'b0; pkt_i.eop = 1'b0; pkt_i.empty = '0;
        if (mq.size() != 0) begin
            meta_i.valid = 1'b1; meta_i.data = mq[0];
        end
        if (uq.size() != 0) begin
            usr_i.valid = 1'b1; usr_i.data = uq[0].d; usr_i.eop = uq[0].eop;
        end
        if (pq.size() != 0) begin
            pkt_i.valid = 1'b1; pkt_i.data = pq[0].d; pkt_i.sop = pq[0].sop;
            pkt_i.eop = pq[0].eop; pkt_i.empty = pq[0].emp;
        end
        usr_o.ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        meta_o.ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        pkt_o.ready  = hold_pkt ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic step();
        bit xm, xu, xp;
        @(negedge clk);
        if (usr_o.valid && usr_o.ready)
            obsq.push_back(enc(2'd0, usr_o.sop, usr_o.eop, {1'b0, usr_o.empty}, {17'd0, usr_o.data}));
        if (meta_o.valid && meta_o.ready)
            obsq.push_back(enc(2'd1, meta_o.sop, meta_o.eop, meta_o.empty, meta_o.data));
        if (pkt_o.valid && pkt_o.ready)
            obsq.push_back(enc(2'd2, pkt_o.sop, pkt_o.eop, {1'b0, pkt_o.empty}, {17'd0, pkt_o.data}));
        xm = meta_i.valid && meta_i.ready;
        xu = usr_i.valid && usr_i.ready;
        xp = pkt_i.valid && pkt_i.ready;
        @(posedge clk);
        #1;
        if (xm) void'(mq.pop_front());
        if (xu) void'(uq.pop_front());
        if (xp) void'(pq.pop_front());
        drive();
    endtask

    // Queues one packet on the inputs and appends its expected egress beats.
    task automatic add_pkt(input int unsigned nbeats, input bit sop2);
        logic [511:0] m, d;
        int unsigned  cnt;
        logic         ovf, last, s, e;
        logic [5:0]   em;
        meta_out_t    mo;
        cnt = 0;
        ovf = 1'b0;
        m = '0;
        m[31:0]    = pidx;
        m[511:480] = 32'hC0DE_0000 ^ pidx;
        mq.push_back(m);
        foreach (rid[i]) begin
            d = '0;
            d[15:0]  = 16'(rid[i]);
            d[47:16] = seq;
            seq++;
            last = (i == rid.size() - 1);
            uq.push_back('{d: d, eop: last});
            if (rid[i] != 0 && cnt < 32) begin
                expq.push_back(enc(2'd0, cnt == 0, last, 7'd0, {17'd0, d}));
                cnt++;
                exp_rule++;
            end else begin
                if (rid[i] != 0) begin
                    ovf = 1'b1;
                    exp_drop++;
                end
                if (last && cnt > 0) expq.push_back(enc(2'd0, 1'b0, 1'b1, 7'd0, '0));
            end
        end
        mo.ovf      = ovf;
        mo.rule_cnt = 16'(cnt);
        mo.meta     = m;
        expq.push_back(enc(2'd1, 1'b1, 1'b1, 7'd0, mo));
        for (int unsigned b = 0; b < nbeats; b++) begin
            d = '0;
            d[31:0]  = seq;
            d[63:32] = pidx;
            seq++;
            s  = (b == 0) || (b == 1 && sop2);
            e  = (b == nbeats - 1);
            em = e ? 6'(b + 7) : 6'd0;
            pq.push_back('{d: d, sop: s, eop: e, emp: em});
`ifdef NF_JOIN_SOP_CHECK_EN
            if (s && b != 0) begin
                expq.push_back(enc(2'd2, s, 1'b1, {1'b0, em}, {17'd0, d}));
                break;
            end
`endif
            expq.push_back(enc(2'd2, s, e, {1'b0, em}, {17'd0, d}));
        end
        exp_pkt++;
        pidx++;
    endtask

    task automatic run(input string tag, input int unsigned budget);
        int unsigned n;
        n = 0;
        drive();
        while ((mq.size() + uq.size() + pq.size() != 0 || obsq.size() < expq.size()) && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
        chk({tag, "_in_budget"}, 600'(n < budget), 600'(1));
        chk({tag, "_beats"}, 600'(obsq.size()), 600'(expq.size()));
        for (int i = 0; i < expq.size() && i < obsq.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), obsq[i], expq[i]);
        obsq.delete();
        expq.delete();
        chk({tag, "_stats_pkt"},  600'(stats_pkt),       600'(exp_pkt));
        chk({tag, "_stats_rule"}, 600'(stats_rule),      600'(exp_rule));
        chk({tag, "_stats_drop"}, 600'(stats_drop_rule), 600'(exp_drop));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pkt_o_valid"},  600'(pkt_o.valid),     600'(0));
        chk({tag, "_meta_o_valid"}, 600'(meta_o.valid),    600'(0));
        chk({tag, "_usr_o_valid"},  600'(usr_o.valid),     600'(0));
        chk({tag, "_pkt_i_ready"},  600'(pkt_i.ready),     600'(0));
        chk({tag, "_meta_i_ready"}, 600'(meta_i.ready),    600'(0));
        chk({tag, "_usr_i_ready"},  600'(usr_i.ready),     600'(0));
        chk({tag, "_stats_pkt"},    600'(stats_pkt),       600'(0));
        chk({tag, "_stats_rule"},   600'(stats_rule),      600'(0));
        chk({tag, "_stats_drop"},   600'(stats_drop_rule), 600'(0));
    endtask

    initial begin
        int unsigned n, nr;
        exp_pkt  = 0;
        exp_rule = 0;
        exp_drop = 0;
        meta_i.sop = 1'b1; meta_i.eop = 1'b1; meta_i.empty = '0;
        usr_i.sop  = 1'b0; usr_i.empty = '0;
        drive();
        #1 rst_n = 1'b0;
        #2;
        chk_quiet("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        rid = '{5, 9, 12};
        add_pkt(3, 1'b0);
        run("basic", 200);
        chk("basic_pkt_const",  600'(stats_pkt),  600'(1));
        chk("basic_rule_const", 600'(stats_rule), 600'(3));

        rid = '{0};
        add_pkt(2, 1'b0);
        run("zero_rule", 200);
        chk("zero_rule_const", 600'(stats_rule), 600'(3));

        rid.delete();
        for (int unsigned i = 1; i <= 40; i++) rid.push_back(i + 100);
        add_pkt(1, 1'b0);
        run("overflow", 400);
        chk("overflow_drop_const", 600'(stats_drop_rule), 600'(8));
        chk("overflow_rule_const", 600'(stats_rule),      600'(35));

        rid = '{7, 0};
        add_pkt(3, 1'b1);
        run("sop2", 200);
`ifdef NF_JOIN_SOP_CHECK_EN
        chk("sop2_proto_err", 600'(proto_err), 600'(1));
`endif
        rid = '{11};
        add_pkt(2, 1'b0);
        run("after_sop2", 200);
`ifdef NF_JOIN_SOP_CHECK_EN
        chk("proto_err_sticky", 600'(proto_err), 600'(1));
`endif

        bp = 1'b1;
        for (int unsigned p = 0; p < 100; p++) begin
            rid.delete();
            nr = (p % 25 == 24) ? 34 : $urandom_range(1, 6);
            for (int unsigned j = 0; j < nr; j++)
                rid.push_back(($urandom_range(0, 3) == 0 && nr < 30) ? 0 : $urandom_range(1, 65535));
            add_pkt($urandom_range(1, 4), 1'b0);
        end
        run("backpressure", 30000);
        bp = 1'b0;

        rid = '{3};
        add_pkt(4, 1'b0);
        hold_pkt = 1'b1;
        drive();
        n = 0;
        while (obsq.size() < 2 && n < 100) begin
            step();
            n++;
        end
        #1;
        chk("midpkt_reached", 600'(n < 100), 600'(1));
        chk("midpkt_pkt_valid", 600'(pkt_o.valid), 600'(1));
        rst_n = 1'b0;
        #2;
        chk_quiet("midpkt_reset");
        mq.delete(); uq.delete(); pq.delete(); obsq.delete(); expq.delete();
        exp_pkt  = 0;
        exp_rule = 0;
        exp_drop = 0;
        hold_pkt = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rid = '{21, 22};
        add_pkt(2, 1'b0);
        run("post_reset", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
